draw_scheduler: RTL and testbench

Command-driven sequencer for the pixel-drawing datapath (start-point registers, x/y coordinate registers, colour source mux). It accepts one draw command at a time from the game FSM: clear screen, full-screen image, or 40×40 battle sprite. It then emits the select, load and count-enable strobes that make the datapath walk every pixel of the region, with one `plot` pulse per pixel and a `done` pulse at the end. Its own row/column counters are the authority for region completion.

---
 rtl/draw_pkg.sv | 40 ++++
 rtl/pixel_scan_counter.sv | 45 ++++
 rtl/draw_scheduler.sv | 156 +++++++++++++++
 tb/tb_draw_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared encodings and defaults for the draw scheduler.
// Contents: command op codes, xySel codes, start-y select codes, FSM state
// enum, region dimension defaults, valid sprite start-point range and the
// command rejection check.
package draw_pkg;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_FULL   = 2'b01;
  localparam logic [1:0] OP_SPRITE = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [1:0] XY_START  = 2'b00;
  localparam logic [1:0] XY_FULL   = 2'b01;
  localparam logic [1:0] XY_SPRITE = 2'b10;

  localparam logic [1:0] YINIT_FULL   = 2'b00;
  localparam logic [1:0] YINIT_SPRITE = 2'b01;

  localparam int FULL_W_DEF = 160;
  localparam int FULL_H_DEF = 120;
  localparam int SPR_W_DEF  = 40;
  localparam int SPR_H_DEF  = 40;

  localparam logic [3:0] SPR_POS_MIN = 4'd1;
  localparam logic [3:0] SPR_POS_MAX = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_START,
    S_SCAN,
    S_DONE
  } state_e;

  function automatic logic cmd_rejected(input logic [1:0] op, input logic [3:0] pos);
    return (op == OP_RSVD) ||
           ((op == OP_SPRITE) && ((pos < SPR_POS_MIN) || (pos > SPR_POS_MAX)));
  endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// Column/row scan counter; it decides when the drawn region is complete.
// Ports:
//   clk, resetn       clock, async active-low reset
//   clear             zero both counters (START state)
//   advance           step one pixel (SCAN without stall)
//   w, h              region width/height
//   row_end           current pixel is the last column of its row
//   last              current pixel is the final pixel of the region
module pixel_scan_counter
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       advance,
  input  logic [7:0] w,
  input  logic [6:0] h,
  output logic       row_end,
  output logic       last
);

  logic [7:0] col;
  logic [6:0] row;

  assign row_end = (col == (w - 8'd1));
  assign last    = row_end && (row == (h - 7'd1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (row_end) begin
        col <= '0;
        row <= row + 7'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Command-driven sequencer for the pixel-drawing datapath. Accepts one
// CLEAR / FULL / SPRITE command at a time and emits the start-point,
// coordinate and colour strobes that walk every pixel of the region.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_op, cmd_mem, cmd_pos    operation, colour source, sprite start point
//   stall                       pixel sink busy, freezes the scan
//   xInitSel..yInitLoad         start-point register controls
//   xySel, xLoad, yLoad         coordinate register source/enables
//   xCountUp, yCountUp          coordinate advance strobes
//   memorySel, black            colour source / force black
//   plot, done, err             pixel write, completion, rejected command
//
// state   | meaning
// S_IDLE  | waiting for a command, cmd_ready=1
// S_INIT  | load start-point registers
// S_START | load coordinate registers from start point, clear counters
// S_SCAN  | one plot per non-stalled cycle until the terminal pixel
// S_DONE  | one-cycle done (and err for rejected commands)
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int FULL_W = FULL_W_DEF,
  parameter int FULL_H = FULL_H_DEF,
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_mem,
  input  logic [3:0] cmd_pos,
  input  logic       stall,
  output logic [3:0] xInitSel,
  output logic [1:0] yInitSel,
  output logic       xInitLoad,
  output logic       yInitLoad,
  output logic [1:0] xySel,
  output logic       xLoad,
  output logic       yLoad,
  output logic       xCountUp,
  output logic       yCountUp,
  output logic [4:0] memorySel,
  output logic       black,
  output logic       plot,
  output logic       done,
  output logic       err
);

  state_e     state, state_nxt;
  logic [1:0] op_q;
  logic [3:0] pos_q;
  logic       err_q;
  logic       accept;
  logic       is_sprite;
  logic [7:0] reg_w;
  logic [6:0] reg_h;
  logic       row_end, last;

  assign accept    = cmd_valid && (state == S_IDLE);
  assign is_sprite = (op_q == OP_SPRITE);
  assign reg_w     = is_sprite ? 8'(SPR_W) : 8'(FULL_W);
  assign reg_h     = is_sprite ? 7'(SPR_H) : 7'(FULL_H);

  pixel_scan_counter u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state == S_START),
    .advance ((state == S_SCAN) && !stall),
    .w       (reg_w),
    .h       (reg_h),
    .row_end (row_end),
    .last    (last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      op_q      <= '0;
      pos_q     <= '0;
      err_q     <= 1'b0;
      memorySel <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q      <= cmd_op;
        pos_q     <= cmd_pos;
        err_q     <= cmd_rejected(cmd_op, cmd_pos);
        // CLEAR draws black; the colour index is forced to 0 so it never
        // shows a stale source.
        memorySel <= (cmd_op == OP_CLEAR) ? 5'd0 : cmd_mem;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    xInitSel  = '0;
    yInitSel  = YINIT_FULL;
    xInitLoad = 1'b0;
    yInitLoad = 1'b0;
    xySel     = XY_START;
    xLoad     = 1'b0;
    yLoad     = 1'b0;
    xCountUp  = 1'b0;
    yCountUp  = 1'b0;
    plot      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    black     = (state != S_IDLE) && (op_q == OP_CLEAR);
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_rejected(cmd_op, cmd_pos) ? S_DONE : S_INIT;
      end
      S_INIT: begin
        xInitLoad = 1'b1;
        yInitLoad = 1'b1;
        if (is_sprite) begin
          xInitSel = pos_q;
          yInitSel = YINIT_SPRITE;
        end
        state_nxt = S_START;
      end
      S_START: begin
        xLoad     = 1'b1;
        yLoad     = 1'b1;
        state_nxt = S_SCAN;
      end
      S_SCAN: begin
        xySel = is_sprite ? XY_SPRITE : XY_FULL;
        // Loads stay high during a stall; the datapath holds because the
        // count strobes drop.
        xLoad = 1'b1;
        yLoad = 1'b1;
        if (!stall) begin
          plot     = 1'b1;
          xCountUp = 1'b1;
          yCountUp = row_end;
          if (last) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

  logic       clk = 1'b0;
  logic       resetn, cmd_valid, stall;
  logic [1:0] cmd_op;
  logic [4:0] cmd_mem;
  logic [3:0] cmd_pos;
  logic       cmd_ready;
  logic [3:0] xInitSel;
  logic [1:0] yInitSel, xySel;
  logic       xInitLoad, yInitLoad, xLoad, yLoad, xCountUp, yCountUp;
  logic [4:0] memorySel;
  logic       black, plot, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  draw_scheduler dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mem(cmd_mem), .cmd_pos(cmd_pos), .stall(stall),
    .xInitSel(xInitSel), .yInitSel(yInitSel), .xInitLoad(xInitLoad), .yInitLoad(yInitLoad),
    .xySel(xySel), .xLoad(xLoad), .yLoad(yLoad), .xCountUp(xCountUp), .yCountUp(yCountUp),
    .memorySel(memorySel), .black(black), .plot(plot), .done(done), .err(err)
  );

  typedef struct {
    int done_cyc; int plots; int ycnt; int ybad; int err; int mem_done;
    int black_cycles; int xinit; int yinit; int init_cyc; int init_cnt;
    int start_cyc; int first_plot; int strobes; int stall_cycles; int stall_bad;
    int xy_bad; int ready_busy; int timeout; int aborted;
  } obs_t;

  typedef struct {
    int done_cyc; int plots; int ycnt; int err; int mem; int black_cycles;
    int xinit; int yinit;
  } exp_t;

  exp_t exp_q[$];

  // Drives one command and observes the DUT cycle by cycle until done
  // (cycle 1 = first cycle after the accept edge). Optional stall pattern,
  // reset abort after abort_at plots, or cmd_valid held with a reserved op.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] mem, input logic [3:0] pos,
                         input bit do_stall, input int abort_at, input bit hold, output obs_t o);
    int cyc, w, st_a, st_b;
    bit s, fin;
    o = '{default: 0};
    o.done_cyc = -1; o.init_cyc = -1; o.start_cyc = -1; o.first_plot = -1;
    w = (op == 2'b10) ? 40 : 160;
    st_a = 0; st_b = 0; fin = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_mem = mem; cmd_pos = pos;
    @(posedge clk);
    #1;
    if (hold) begin cmd_op = 2'b11; cmd_mem = 5'd3; cmd_pos = 4'd0; end
    else cmd_valid = 1'b0;
    cyc = 1;
    while (!fin && cyc < 25000) begin
      @(negedge clk);
      s = do_stall && ((o.plots == 100 && st_a < 5) || (o.plots == 159 && st_b < 3));
      if (s && o.plots == 100) st_a++;
      if (s && o.plots == 159) st_b++;
      stall = s;
      #1;
      if (xInitLoad || yInitLoad) begin
        o.init_cnt++; o.init_cyc = cyc; o.xinit = int'(xInitSel); o.yinit = int'(yInitSel);
      end
      if (xLoad && xySel == 2'b00 && !plot) o.start_cyc = cyc;
      if (plot) begin
        if (o.first_plot < 0) o.first_plot = cyc;
        o.plots++;
        if (xySel != ((w == 40) ? 2'b10 : 2'b01) || !xCountUp) o.xy_bad++;
      end
      if (yCountUp) begin
        o.ycnt++;
        if (!plot || (o.plots % w) != 0) o.ybad++;
      end
      if (plot || xLoad || yLoad || xInitLoad || yInitLoad || xCountUp || yCountUp) o.strobes++;
      if (stall && o.first_plot >= 0) begin
        o.stall_cycles++;
        if (plot || xCountUp || yCountUp) o.stall_bad++;
      end
      if (black) o.black_cycles++;
      if (cmd_ready) o.ready_busy++;
      if (abort_at >= 0 && o.plots == abort_at) begin
        resetn = 1'b0; o.aborted = 1; fin = 1;
      end else if (done) begin
        o.done_cyc = cyc; o.err = int'(err); o.mem_done = int'(memorySel); fin = 1;
      end else begin
        @(posedge clk);
        cyc++;
      end
    end
    stall = 1'b0;
    if (!fin) o.timeout = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    checks++;
    if ({xInitSel, yInitSel, xInitLoad, yInitLoad, xySel, xLoad, yLoad, xCountUp, yCountUp,
         memorySel, black, plot, done, err} !== 23'd0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs exp all 0");
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_sprite();
    obs_t o; exp_t e;
    exp_q.push_back('{done_cyc: 1603, plots: 1600, ycnt: 40, err: 0, mem: 10, black_cycles: 0, xinit: 8, yinit: 1});
    run_cmd(2'b10, 5'd10, 4'd8, 0, -1, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.timeout != 0)          begin errors++; $display("FAIL sprite_timeout got %0d exp 0", o.timeout); end
    checks++; if (o.done_cyc != e.done_cyc) begin errors++; $display("FAIL sprite_done_cyc got %0d exp %0d", o.done_cyc, e.done_cyc); end
    checks++; if (o.plots != e.plots)       begin errors++; $display("FAIL sprite_plots got %0d exp %0d", o.plots, e.plots); end
    checks++; if (o.ycnt != e.ycnt)         begin errors++; $display("FAIL sprite_ycount got %0d exp %0d", o.ycnt, e.ycnt); end
    checks++; if (o.ybad != 0)              begin errors++; $display("FAIL sprite_ycount_pos got %0d misplaced exp 0", o.ybad); end
    checks++; if (o.err != e.err)           begin errors++; $display("FAIL sprite_err got %0d exp %0d", o.err, e.err); end
    checks++; if (o.mem_done != e.mem)      begin errors++; $display("FAIL sprite_mem got %0d exp %0d", o.mem_done, e.mem); end
    checks++; if (o.xinit != e.xinit || o.yinit != e.yinit) begin errors++; $display("FAIL sprite_init_sel got %0d/%0d exp %0d/%0d", o.xinit, o.yinit, e.xinit, e.yinit); end
    checks++; if (o.init_cyc != 1 || o.init_cnt != 1) begin errors++; $display("FAIL sprite_init_cyc got %0d x%0d exp 1 x1", o.init_cyc, o.init_cnt); end
    checks++; if (o.start_cyc != 2)         begin errors++; $display("FAIL sprite_start_cyc got %0d exp 2", o.start_cyc); end
    checks++; if (o.first_plot != 3)        begin errors++; $display("FAIL sprite_first_plot got %0d exp 3", o.first_plot); end
    checks++; if (o.xy_bad != 0)            begin errors++; $display("FAIL sprite_xysel got %0d bad exp 0", o.xy_bad); end
    checks++; if (o.black_cycles != e.black_cycles) begin errors++; $display("FAIL sprite_black got %0d exp %0d", o.black_cycles, e.black_cycles); end
    checks++; if (o.ready_busy != 0)        begin errors++; $display("FAIL sprite_ready_busy got %0d exp 0", o.ready_busy); end
  endtask

  task automatic test_reject();
    obs_t o; exp_t e;
    logic [1:0] ops[4]  = '{2'b10, 2'b11, 2'b10, 2'b10};
    logic [3:0] poss[4] = '{4'd14, 4'd5, 4'd0, 4'd15};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{done_cyc: 1, plots: 0, ycnt: 0, err: 1, mem: 9, black_cycles: 0, xinit: 0, yinit: 0});
      run_cmd(ops[i], 5'd9, poss[i], 0, -1, 0, o);
      e = exp_q.pop_front();
      checks++; if (o.done_cyc != e.done_cyc) begin errors++; $display("FAIL reject%0d_done_cyc got %0d exp %0d", i, o.done_cyc, e.done_cyc); end
      checks++; if (o.err != e.err)           begin errors++; $display("FAIL reject%0d_err got %0d exp %0d", i, o.err, e.err); end
      checks++; if (o.strobes != 0)           begin errors++; $display("FAIL reject%0d_strobes got %0d exp 0", i, o.strobes); end
    end
  endtask

  task automatic test_clear();
    obs_t o; exp_t e;
    exp_q.push_back('{done_cyc: 19203, plots: 19200, ycnt: 120, err: 0, mem: 0, black_cycles: 19203, xinit: 0, yinit: 0});
    run_cmd(2'b00, 5'd7, 4'd5, 0, -1, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.done_cyc != e.done_cyc) begin errors++; $display("FAIL clear_done_cyc got %0d exp %0d", o.done_cyc, e.done_cyc); end
    checks++; if (o.plots != e.plots)       begin errors++; $display("FAIL clear_plots got %0d exp %0d", o.plots, e.plots); end
    checks++; if (o.ycnt != e.ycnt || o.ybad != 0) begin errors++; $display("FAIL clear_ycount got %0d bad %0d exp %0d bad 0", o.ycnt, o.ybad, e.ycnt); end
    checks++; if (o.black_cycles != e.black_cycles) begin errors++; $display("FAIL clear_black got %0d exp %0d", o.black_cycles, e.black_cycles); end
    checks++; if (o.mem_done != e.mem)      begin errors++; $display("FAIL clear_mem got %0d exp %0d", o.mem_done, e.mem); end
    checks++; if (o.xinit != e.xinit || o.yinit != e.yinit) begin errors++; $display("FAIL clear_init_sel got %0d/%0d exp 0/0", o.xinit, o.yinit); end
    checks++; if (o.xy_bad != 0)            begin errors++; $display("FAIL clear_xysel got %0d bad exp 0", o.xy_bad); end
    @(negedge clk); #1;
    checks++; if (black !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL clear_idle got black %b ready %b exp 0 1", black, cmd_ready); end
  endtask

  task automatic test_stall();
    obs_t o; exp_t e;
    exp_q.push_back('{done_cyc: 19211, plots: 19200, ycnt: 120, err: 0, mem: 21, black_cycles: 0, xinit: 0, yinit: 0});
    run_cmd(2'b01, 5'd21, 4'd2, 1, -1, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.done_cyc != e.done_cyc) begin errors++; $display("FAIL stall_done_cyc got %0d exp %0d", o.done_cyc, e.done_cyc); end
    checks++; if (o.plots != e.plots)       begin errors++; $display("FAIL stall_plots got %0d exp %0d", o.plots, e.plots); end
    checks++; if (o.ycnt != e.ycnt || o.ybad != 0) begin errors++; $display("FAIL stall_ycount got %0d bad %0d exp %0d bad 0", o.ycnt, o.ybad, e.ycnt); end
    checks++; if (o.stall_cycles != 8)      begin errors++; $display("FAIL stall_cycles got %0d exp 8", o.stall_cycles); end
    checks++; if (o.stall_bad != 0)         begin errors++; $display("FAIL stall_strobes got %0d exp 0", o.stall_bad); end
    checks++; if (o.mem_done != e.mem)      begin errors++; $display("FAIL stall_mem got %0d exp %0d", o.mem_done, e.mem); end
    @(negedge clk); #1;
    checks++; if (memorySel !== 5'd21 || cmd_ready !== 1'b1) begin errors++; $display("FAIL stall_idle_mem got %0d ready %b exp 21 1", memorySel, cmd_ready); end
  endtask

  task automatic test_abort_reset();
    obs_t o; exp_t e;
    int dones;
    run_cmd(2'b10, 5'd5, 4'd3, 0, 500, 0, o);
    #1;
    checks++; if (o.aborted != 1) begin errors++; $display("FAIL abort_reached got %0d exp 1", o.aborted); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", cmd_ready); end
    checks++;
    if ({xInitSel, yInitSel, xInitLoad, yInitLoad, xySel, xLoad, yLoad, xCountUp, yCountUp,
         memorySel, black, plot, done, err} !== 23'd0) begin
      errors++; $display("FAIL abort_outputs got nonzero outputs exp all 0");
    end
    @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    repeat (20) begin @(negedge clk); #1; if (done) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", dones); end
    exp_q.push_back('{done_cyc: 1603, plots: 1600, ycnt: 40, err: 0, mem: 31, black_cycles: 0, xinit: 13, yinit: 1});
    run_cmd(2'b10, 5'd31, 4'd13, 0, -1, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.done_cyc != e.done_cyc) begin errors++; $display("FAIL after_abort_done_cyc got %0d exp %0d", o.done_cyc, e.done_cyc); end
    checks++; if (o.plots != e.plots)       begin errors++; $display("FAIL after_abort_plots got %0d exp %0d", o.plots, e.plots); end
    checks++; if (o.xinit != e.xinit || o.yinit != e.yinit) begin errors++; $display("FAIL after_abort_init_sel got %0d/%0d exp %0d/%0d", o.xinit, o.yinit, e.xinit, e.yinit); end
    checks++; if (o.mem_done != e.mem)      begin errors++; $display("FAIL after_abort_mem got %0d exp %0d", o.mem_done, e.mem); end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    exp_q.push_back('{done_cyc: 1603, plots: 1600, ycnt: 40, err: 0, mem: 10, black_cycles: 0, xinit: 1, yinit: 1});
    run_cmd(2'b10, 5'd10, 4'd1, 0, -1, 1, o);
    e = exp_q.pop_front();
    checks++; if (o.done_cyc != e.done_cyc) begin errors++; $display("FAIL b2b_done_cyc got %0d exp %0d", o.done_cyc, e.done_cyc); end
    checks++; if (o.ready_busy != 0)        begin errors++; $display("FAIL b2b_ready_busy got %0d exp 0", o.ready_busy); end
    checks++; if (o.mem_done != e.mem)      begin errors++; $display("FAIL b2b_mem_latched got %0d exp %0d", o.mem_done, e.mem); end
    checks++; if (o.xinit != e.xinit)       begin errors++; $display("FAIL b2b_xinit got %0d exp %0d", o.xinit, e.xinit); end
    @(negedge clk); #1;
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got ready %b done %b exp 1 0", cmd_ready, done); end
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_second got done %b err %b ready %b exp 1 1 0", done, err, cmd_ready); end
    checks++; if (memorySel !== 5'd3) begin errors++; $display("FAIL b2b_second_mem got %0d exp 3", memorySel); end
    @(negedge clk); #1;
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_settle got ready %b done %b exp 1 0", cmd_ready, done); end
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_mem = '0; cmd_pos = '0; stall = 1'b0;
    test_reset();
    test_sprite();
    test_reject();
    test_clear();
    test_stall();
    test_abort_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
